// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FAULT encoding exists always; it is only reachable with FETCH_MISALIGN_CHECK_EN.
package fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response and decode valid/ready signals of the fetch unit.
// master = fetch unit side, slave = memory + decode side.
interface pc_fetch_unit_if #(
    parameter int WIDTH = 32
);
    import fetch_pkg::*;

    logic                   imem_req;
    logic [WIDTH-1:0]       imem_addr;
    logic                   imem_gnt;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [WIDTH-1:0]       instr_pc;
    logic                   instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetcher (REQ -> WAIT -> HOLD).
// FETCH_MISALIGN_CHECK_EN adds a FAULT state and the fetch_misaligned output.
//
// state | meaning
// IDLE  | one cycle after reset release, nothing issued
// REQ   | imem_req asserted (unless stalled) at pc, waiting for gnt
// WAIT  | request granted, waiting for rvalid; kill marks a stale response
// HOLD  | instruction presented to decode until accepted or redirected
// FAULT | misaligned redirect target, fetch halted until aligned redirect
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic             fetch_misaligned,
`endif
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] pc_target,
    input  logic             redirect,
    input  logic             stall,
    pc_fetch_unit_if.master  bus
);

    fetch_state_t           state, state_nxt;
    logic [WIDTH-1:0]       pc_q, pc_nxt;
    logic                   kill, kill_nxt;
    logic                   capture;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [WIDTH-1:0]       instr_pc_q;
    logic [WIDTH-1:0]       target_load;
    logic                   req_fire;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;

    assign target_load      = pc_target;
    assign misaligned       = !word_aligned(pc_target[1:0]);
    assign fetch_misaligned = (state == FAULT);
`else
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    assign target_load = pc_target & ALIGN_MASK;
`endif

    assign bus.imem_req    = (state == REQ) && !stall;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state == HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign pc              = pc_q;
    assign req_fire        = bus.imem_req && bus.imem_gnt;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        kill_nxt  = kill;
        capture   = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect) begin
                    pc_nxt = target_load;
                    // a grant in the redirect cycle leaves a response that must be dropped
                    kill_nxt  = req_fire;
                    state_nxt = req_fire ? WAIT : REQ;
                end else if (req_fire) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_nxt = target_load;
                    if (bus.imem_rvalid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    if (kill) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = target_load;
                    state_nxt = REQ;
                end else if (bus.instr_ready && !stall) begin
                    pc_nxt    = pc_plus4;
                    state_nxt = REQ;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            FAULT: begin
                if (redirect) begin
                    pc_nxt    = target_load;
                    state_nxt = REQ;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        // any in-flight response lands in FAULT, where rvalid is ignored
        if (redirect && misaligned && (state != IDLE)) begin
            state_nxt = FAULT;
            kill_nxt  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            kill       <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            kill  <= kill_nxt;
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc_q;
            end
        end
    end

endmodule
